// File: rtl/tile_fetch_agu_pkg.sv
// Shared definitions for the descriptor-driven tile fetch address generator.
// Holds the FSM state encoding and the standard buffer region base addresses.
package tile_fetch_agu_pkg;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Standard region bases used by the arbiter to build descriptors.
    localparam logic [15:0] W_BASE   = 16'h0000;
    localparam logic [15:0] B_BASE   = 16'h0400;
    localparam logic [15:0] I_BASE   = 16'h0800;
    localparam logic [15:0] K_BASE   = 16'h0C00;
    localparam logic [15:0] V_BASE   = 16'h1000;
    localparam logic [15:0] KTQ_BASE = 16'h1400;
    localparam logic [15:0] SV_BASE  = 16'h1800;
    localparam logic [15:0] H_BASE   = 16'h1C00;
    localparam logic [15:0] FFN_BASE = 16'h2000;
    localparam logic [15:0] O_BASE   = 16'h3000;

endpackage

// File: rtl/tile_fetch_agu_walk_counter.sv
// Walk counter: row/column indices plus a row-base accumulator and last flag.
// Ports: init_i/init_base_i restart the walk, step_i advances one beat,
// c_o/row_base_o give the current position, last_o flags the final beat.
module agu_walk_counter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    input  logic [ADDR_WIDTH-1:0] init_base_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [DIM_WIDTH-1:0]  rows_i,
    input  logic [DIM_WIDTH-1:0]  cols_i,
    input  logic                  transpose_i,
    input  logic                  step_i,
    output logic [DIM_WIDTH-1:0]  c_o,
    output logic [ADDR_WIDTH-1:0] row_base_o,
    output logic                  last_o
);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    logic [DIM_WIDTH-1:0]  r_q, r_d;
    logic [DIM_WIDTH-1:0]  c_q, c_d;
    logic [ADDR_WIDTH-1:0] rb_q, rb_d;
    logic                  r_last;
    logic                  c_last;

    assign r_last = (r_q == rows_i - DIM_ONE);
    assign c_last = (c_q == cols_i - DIM_ONE);

    always_comb begin
        r_d  = r_q;
        c_d  = c_q;
        rb_d = rb_q;
        if (init_i) begin
            r_d  = '0;
            c_d  = '0;
            rb_d = init_base_i;
        end else if (step_i) begin
            if (transpose_i) begin
                // Inner index is r; wrapping r rewinds the row base.
                if (r_last) begin
                    r_d  = '0;
                    c_d  = c_q + DIM_ONE;
                    rb_d = base_i;
                end else begin
                    r_d  = r_q + DIM_ONE;
                    rb_d = rb_q + stride_i;
                end
            end else begin
                if (c_last) begin
                    c_d  = '0;
                    r_d  = r_q + DIM_ONE;
                    rb_d = rb_q + stride_i;
                end else begin
                    c_d = c_q + DIM_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            c_q  <= '0;
            rb_q <= '0;
        end else begin
            r_q  <= r_d;
            c_q  <= c_d;
            rb_q <= rb_d;
        end
    end

    assign c_o        = c_q;
    assign row_base_o = rb_q;
    assign last_o     = r_last && c_last;

endmodule

// File: rtl/tile_fetch_agu.sv
// Descriptor-driven BRAM read address generator for the arbiter fetch path.
// Ports: cmd_* descriptor handshake, bram_* address stream with backpressure,
// abort cancel, fetch_done pulse, busy and beat_count status.
module tile_fetch_agu
    import tile_fetch_agu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DIM_WIDTH    = 10,
    parameter int STRIDE_WIDTH = 16,
    parameter int BANK_OFFSET  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [STRIDE_WIDTH-1:0] cmd_stride,
    input  logic [DIM_WIDTH-1:0]    cmd_rows,
    input  logic [DIM_WIDTH-1:0]    cmd_cols,
    input  logic                    cmd_transpose,
    input  logic                    cmd_bank,
    input  logic                    abort,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic                    bram_en,
    input  logic                    bram_ready,
    output logic                    fetch_done,
    output logic                    busy,
    output logic [2*DIM_WIDTH-1:0]  beat_count
);

    localparam int BW = 2 * DIM_WIDTH;
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);
    localparam logic [ADDR_WIDTH-1:0] BANK_OFS = ADDR_WIDTH'(BANK_OFFSET);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
    logic                  tr_q, tr_d;
    logic [BW-1:0]         beat_q, beat_d;

    logic                  accept;
    logic                  step;
    logic                  last;
    logic [ADDR_WIDTH-1:0] eff_base;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [DIM_WIDTH-1:0]  col;

    assign eff_base = cmd_base + (cmd_bank ? BANK_OFS : '0);
    assign accept   = (state_q == ST_IDLE) && cmd_valid;
    // An aborted cycle never advances the walk.
    assign step     = (state_q == ST_ISSUE) && bram_ready && !abort;

    agu_walk_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_walk (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_i      (accept),
        .init_base_i (eff_base),
        .base_i      (base_q),
        .stride_i    (stride_q),
        .rows_i      (rows_q),
        .cols_i      (cols_q),
        .transpose_i (tr_q),
        .step_i      (step),
        .c_o         (col),
        .row_base_o  (row_base),
        .last_o      (last)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        stride_d = stride_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        tr_d     = tr_q;
        beat_d   = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    base_d   = eff_base;
                    stride_d = ADDR_WIDTH'(cmd_stride);
                    rows_d   = cmd_rows;
                    cols_d   = cmd_cols;
                    tr_d     = cmd_transpose;
                    beat_d   = '0;
                    if (cmd_rows == '0 || cmd_cols == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    beat_d = beat_q + BEAT_ONE;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Cancelled descriptors are dropped so nothing stale survives.
        if (abort && state_q != ST_IDLE) begin
            base_d   = '0;
            stride_d = '0;
            rows_d   = '0;
            cols_d   = '0;
            tr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            tr_q     <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            tr_q     <= tr_d;
            beat_q   <= beat_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign bram_en    = (state_q == ST_ISSUE);
    assign bram_addr  = bram_en ? row_base + ADDR_WIDTH'(col) : '0;
    // Abort in DONE suppresses the completion pulse.
    assign fetch_done = (state_q == ST_DONE) && !abort;
    assign busy       = (state_q != ST_IDLE);
    assign beat_count = beat_q;

endmodule

// File: tb/tb_tile_fetch_agu.sv
// Scoreboard bench for tile_fetch_agu.
// Stimulus pushes expected addresses/completions; a negedge monitor checks.
module tb_tile_fetch_agu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_base = '0;
    logic [15:0] cmd_stride = '0;
    logic [9:0]  cmd_rows = '0;
    logic [9:0]  cmd_cols = '0;
    logic        cmd_transpose = 1'b0;
    logic        cmd_bank = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] bram_addr;
    logic        bram_en;
    logic        bram_ready = 1'b1;
    logic        fetch_done;
    logic        busy;
    logic [19:0] beat_count;

    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc = 0;

    logic [15:0] exp_addr[$];
    int          exp_done_cyc[$];
    int          exp_done_bc[$];
    logic [15:0] vec[$];

    logic        stalled_prev = 1'b0;
    logic [15:0] held_addr = '0;

    tile_fetch_agu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_stride    (cmd_stride),
        .cmd_rows      (cmd_rows),
        .cmd_cols      (cmd_cols),
        .cmd_transpose (cmd_transpose),
        .cmd_bank      (cmd_bank),
        .abort         (abort),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_ready    (bram_ready),
        .fetch_done    (fetch_done),
        .busy          (busy),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected addresses and completions as the DUT emits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en && stalled_prev)
                chk("addr_hold", bram_addr, held_addr);
            if (bram_en && bram_ready) begin
                if (exp_addr.size() == 0)
                    chk("spurious_beat", bram_en, 1'b0);
                else
                    chk("addr", bram_addr, exp_addr.pop_front());
            end
            stalled_prev = bram_en && !bram_ready;
            held_addr = bram_addr;
            if (fetch_done) begin
                n_done++;
                if (exp_done_cyc.size() == 0) begin
                    chk("spurious_done", fetch_done, 1'b0);
                end else begin
                    chk("done_cycle", cyc, exp_done_cyc.pop_front());
                    chk("done_beats", beat_count, exp_done_bc.pop_front());
                end
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic set_cmd(input logic [15:0] base, input logic [15:0] stride,
                           input logic [9:0] rows, input logic [9:0] cols,
                           input logic tr, input logic bank);
        cmd_base = base;
        cmd_stride = stride;
        cmd_rows = rows;
        cmd_cols = cols;
        cmd_transpose = tr;
        cmd_bank = bank;
        cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input logic [15:0] base, input logic [15:0] stride,
                           input logic [9:0] rows, input logic [9:0] cols,
                           input logic tr, input logic bank,
                           input logic [31:0] stall, input int nstall);
        int t;
        int d0;
        int nb;
        nb = int'(rows) * int'(cols);
        foreach (vec[i]) exp_addr.push_back(vec[i]);
        @(posedge clk); #1;
        set_cmd(base, stride, rows, cols, tr, bank);
        bram_ready = 1'b1;
        @(negedge clk);
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        t = cyc;
        exp_done_cyc.push_back(nb == 0 ? t + 1 : t + 1 + nb + nstall);
        exp_done_bc.push_back(nb);
        d0 = n_done;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k < 32 && n_done == d0; k++) begin
            bram_ready = !stall[k];
            @(negedge clk);
            @(posedge clk); #1;
        end
        bram_ready = 1'b1;
        chk("done_seen", n_done - d0, 32'd1);
        @(negedge clk);
        chk("beat_hold", beat_count, nb);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", {31'd0, bram_en}, 32'd0);
        chk("rst_addr", bram_addr, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_beats", beat_count, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;

        // Row-major 2x3.
        vec = '{16'h0100, 16'h0101, 16'h0102, 16'h0120, 16'h0121, 16'h0122};
        run_cmd(16'h0100, 16'd32, 10'd2, 10'd3, 1'b0, 1'b0, 32'h0, 0);

        // Transposed 3x2, bank 1.
        vec = '{16'h0220, 16'h0520, 16'h0820, 16'h0221, 16'h0521, 16'h0821};
        run_cmd(16'h0200, 16'd768, 10'd3, 10'd2, 1'b1, 1'b1, 32'h0, 0);

        // Backpressure on 2nd and 4th issue cycles.
        vec = '{16'h0100, 16'h0101, 16'h0102, 16'h0120, 16'h0121, 16'h0122};
        run_cmd(16'h0100, 16'd32, 10'd2, 10'd3, 1'b0, 1'b0, 32'h14, 2);

        // Empty command.
        vec = {};
        run_cmd(16'h0300, 16'd32, 10'd0, 10'd5, 1'b0, 1'b0, 32'h0, 0);

        // Abort during the 3rd beat.
        vec = '{16'h0100, 16'h0101, 16'h0102};
        foreach (vec[i]) exp_addr.push_back(vec[i]);
        @(posedge clk); #1;
        set_cmd(16'h0100, 16'd32, 10'd2, 10'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_en", {31'd0, bram_en}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_done", {31'd0, fetch_done}, 32'd0);
        chk("abort_q", exp_addr.size(), 32'd0);
        repeat (3) @(negedge clk);

        // New command after abort: wrap-around.
        vec = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_cmd(16'hFFFE, 16'd1, 10'd1, 10'd4, 1'b0, 1'b0, 32'h0, 0);

        // Reset mid-walk.
        vec = '{16'h0100, 16'h0101};
        foreach (vec[i]) exp_addr.push_back(vec[i]);
        @(posedge clk); #1;
        set_cmd(16'h0100, 16'd32, 10'd2, 10'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'd0, bram_en}, 32'd0);
        chk("mid_rst_addr", bram_addr, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_beats", beat_count, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_q", exp_addr.size(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_done_q", exp_done_cyc.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_fetch_agu.md
Name: tile_fetch_agu

Overview:
- Descriptor-driven BRAM read address generator for the arbiter fetch path.
- Generalises the fixed-region tile fetcher. Each command supplies its own base, row stride, row/column extent, walk order (row-major or transposed) and ping-pong bank.
- Issues one address per accepted beat, with downstream backpressure and abort.
- Sits between the arbiter control FSM and the shared buffer BRAM read port.

Parameters:
- ADDR_WIDTH, 16, BRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- DIM_WIDTH, 10, width of the row and column count fields (max extent 2^DIM_WIDTH - 1).
- STRIDE_WIDTH, 16, width of the row stride field.
- BANK_OFFSET, 32, address offset added when the double-buffer bank bit is 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command descriptor valid.
- cmd_ready  out  1  high when the block can accept a command (IDLE only).
- cmd_base  in  ADDR_WIDTH  region base address.
- cmd_stride  in  STRIDE_WIDTH  address distance between consecutive rows.
- cmd_rows  in  DIM_WIDTH  number of rows (0 = empty).
- cmd_cols  in  DIM_WIDTH  beats per row (0 = empty).
- cmd_transpose  in  1  0 = row-major walk; 1 = column-major walk.
- cmd_bank  in  1  double-buffer bank select.
- abort  in  1  synchronous cancel of the current command.
- bram_addr  out  ADDR_WIDTH  read address.
- bram_en  out  1  address valid / BRAM read enable.
- bram_ready  in  1  downstream accepts the address this cycle.
- fetch_done  out  1  one-cycle pulse when all beats of a command have been issued.
- busy  out  1  high in ISSUE and DONE.
- beat_count  out  2*DIM_WIDTH  beats issued for the current command.

Behaviour:
- Reset values: state IDLE, bram_addr 0, bram_en 0, fetch_done 0, busy 0, beat_count 0, cmd_ready 1.
- States are IDLE, ISSUE and DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch all cmd_* fields and compute eff_base = cmd_base + (cmd_bank ? BANK_OFFSET : 0).
  - If cmd_rows == 0 or cmd_cols == 0, go to DONE. Otherwise go to ISSUE with r = 0, c = 0.
- ISSUE:
  - bram_en = 1, bram_addr = eff_base + r*stride + c, computed incrementally with a row-base accumulator (no multiplier).
  - A beat is consumed only when bram_en && bram_ready. Otherwise bram_addr and bram_en hold.
  - On each beat, beat_count increments.
  - Row-major walk: c is the inner index; on c == cols-1, c wraps to 0 and r increments.
  - Transposed walk: r is the inner index; on r == rows-1, r wraps to 0 and c increments.
  - On the last beat (r == rows-1 and c == cols-1), go to DONE.
- DONE:
  - fetch_done = 1 for exactly one cycle, bram_en = 0, then return to IDLE.
  - beat_count holds its final value until the next command is accepted, then clears.
- Latency: command accepted in cycle T gives the first bram_en in T+1. With bram_ready held high, fetch_done asserts at T+1+rows*cols.
- abort:
  - In ISSUE or DONE: go to IDLE next cycle, bram_en drops, no fetch_done pulse, latched fields discarded.
  - In IDLE: ignored.
  - abort coincident with cmd_valid in IDLE: the command is accepted.
- Address overflow: wraps modulo 2^ADDR_WIDTH with no error flag.
- cmd_valid outside IDLE: ignored (cmd_ready = 0). The command is not queued.
- Reset mid-command: all state clears immediately (asynchronous). No fetch_done.

Decomposition:
- Shared package holds the state encoding localparams (IDLE/ISSUE/DONE) and the standard region base constants (W, b, I, K, V, kTQ, SV, H, FFN buffers, O_buffer). The arbiter uses these to build descriptors.
- One natural sub-module: agu_walk_counter. It takes rows/cols/transpose and a step enable, and produces r, c, the row-base accumulator and a last-beat flag.
- The top level keeps the FSM, the command latch, the bank offset and the handshake.

Test Plan:
- Row-major walk: base=0x0100, stride=32, rows=2, cols=3, bank=0, ready=1 -> addresses 0x100,0x101,0x102,0x120,0x121,0x122; fetch_done exactly 7 cycles after accept; beat_count=6.
- Transposed walk with bank: base=0x0200, stride=768, rows=3, cols=2, bank=1 (BANK_OFFSET=32) -> addresses 0x220,0x520,0x820,0x221,0x521,0x821.
- Backpressure: same as the row-major walk with bram_ready low on the 2nd and 4th cycles -> bram_addr held stable while stalled; the same 6 addresses in order; fetch_done delayed by 2 cycles.
- Empty command: rows=0, cols=5 -> no bram_en; fetch_done one cycle after accept; beat_count=0.
- Abort: abort during the 3rd beat of a 2x3 command -> bram_en low the next cycle, no fetch_done, cmd_ready=1; a new command is then accepted normally.
- Wrap-around and reset: base=0xFFFE, rows=1, cols=4 -> 0xFFFE,0xFFFF,0x0000,0x0001. Deasserting rst_n mid-walk -> all outputs return to reset values immediately.
